// File: rtl/max_search_ctrl_if.sv
// Start/sample/result bundle between a sample source, max_search_ctrl and its consumer.
// master drives commands and samples and takes results; slave is the controller side.
interface max_search_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic             s_valid;
  logic             s_ready;
  logic [9:0]       s_data;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [9:0]       res_max;
  logic [CNT_W-1:0] res_idx;
  logic             res_empty;

  modport master (
    output start, len, abort, s_valid, s_data, res_ready,
    input  s_ready, busy, res_valid, res_max, res_idx, res_empty
  );

  modport slave (
    input  start, len, abort, s_valid, s_data, res_ready,
    output s_ready, busy, res_valid, res_max, res_idx, res_empty
  );
endinterface

// File: rtl/max_search_ctrl.sv
// Streams a burst of 10-bit samples through one strict greater-than comparator and
// returns the maximum and the index of its first occurrence.
module max_search_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  max_search_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccum  = 2'b01,
    StResult = 2'b10
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx_q;
  logic [9:0]       max_q;
  logic             s_ready_q;
  logic             busy_q;
  logic             res_valid_q;
  logic             empty_q;

  // The single comparator: A = incoming sample, B = running maximum.
  logic greaterthan;
  assign greaterthan = bus.s_data > max_q;

  logic last_sample;
  assign last_sample = (cnt_q == len_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      max_q       <= '0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            len_q  <= bus.len;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (bus.len == '0) begin
              state_q     <= StResult;
              max_q       <= '0;
              idx_q       <= '0;
              empty_q     <= 1'b1;
              res_valid_q <= 1'b1;
            end else begin
              state_q   <= StAccum;
              empty_q   <= 1'b0;
              s_ready_q <= 1'b1;
            end
          end
        end
        StAccum: begin
          if (bus.abort) begin
            state_q   <= StIdle;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (bus.s_valid && s_ready_q) begin
            if (cnt_q == '0 || greaterthan) begin
              max_q <= bus.s_data;
              idx_q <= cnt_q;
            end
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_sample) begin
              state_q     <= StResult;
              s_ready_q   <= 1'b0;
              res_valid_q <= 1'b1;
            end
          end
        end
        StResult: begin
          if (bus.res_ready) begin
            state_q     <= StIdle;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          s_ready_q   <= 1'b0;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // abort must block acceptance in its own cycle, so it gates the registered ready.
  assign bus.s_ready   = s_ready_q & ~bus.abort;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_max   = max_q;
  assign bus.res_idx   = idx_q;
  assign bus.res_empty = empty_q;

endmodule

// File: tb/tb_max_search_ctrl.sv
// Scoreboard bench for max_search_ctrl: expected results are queued at burst start
// and compared when the controller presents them.
module tb_max_search_ctrl;

  typedef struct packed {
    logic [9:0] mx;
    logic [7:0] idx;
    logic       empty;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [9:0] smp[$];

  max_search_ctrl_if #(.CNT_W(8)) bus ();

  max_search_ctrl #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  // Two-pass reference: find the peak value, then its first position.
  function automatic exp_t model(input logic [7:0] l, input logic [9:0] s[$]);
    exp_t e;
    e.mx    = '0;
    e.idx   = '0;
    e.empty = (l == 8'd0);
    foreach (s[i]) if (s[i] > e.mx) e.mx = s[i];
    for (int i = s.size() - 1; i >= 0; i--) if (s[i] == e.mx) e.idx = 8'(i);
    return e;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_s_ready"},   bus.s_ready,   0);
    check_eq({tag, "_busy"},      bus.busy,      0);
    check_eq({tag, "_res_valid"}, bus.res_valid, 0);
    check_eq({tag, "_res_max"},   bus.res_max,   0);
    check_eq({tag, "_res_idx"},   bus.res_idx,   0);
    check_eq({tag, "_res_empty"}, bus.res_empty, 0);
  endtask

  task automatic do_start(input logic [7:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("start_busy",      bus.busy,      1);
    check_eq("start_s_ready",   bus.s_ready,   (l != 0));
    check_eq("start_res_valid", bus.res_valid, (l == 0));
  endtask

  task automatic send_samples(input logic [9:0] s[$], input int gap);
    foreach (s[i]) begin
      repeat (gap) begin
        bus.s_valid = 1'b0;
        @(negedge clk);
        check_eq("gap_s_ready", bus.s_ready, 1);
      end
      bus.s_valid = 1'b1;
      bus.s_data  = s[i];
      check_eq("accum_s_ready",   bus.s_ready,   1);
      check_eq("accum_res_valid", bus.res_valid, 0);
      @(negedge clk);
      bus.s_valid = 1'b0;
    end
  endtask

  task automatic wait_result(input int ready_delay);
    int   waits = 0;
    exp_t e;
    while (!bus.res_valid && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check_eq("res_valid_seen", bus.res_valid, 1);
    if (!bus.res_valid) return;
    check_eq("res_latency", waits, 0);
    check_eq("sb_nonempty", (sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    repeat (ready_delay) begin
      check_eq("hold_valid", bus.res_valid, 1);
      check_eq("hold_max",   bus.res_max,   e.mx);
      check_eq("hold_idx",   bus.res_idx,   e.idx);
      @(negedge clk);
    end
    check_eq("res_max",   bus.res_max,   e.mx);
    check_eq("res_idx",   bus.res_idx,   e.idx);
    check_eq("res_empty", bus.res_empty, e.empty);
    check_eq("res_busy",  bus.busy,      1);
    check_eq("res_s_ready", bus.s_ready, 0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check_eq("post_hs_valid", bus.res_valid, 0);
    check_eq("post_hs_busy",  bus.busy,      0);
  endtask

  task automatic run_burst(input logic [7:0] l, input logic [9:0] s[$], input int gap,
                           input int ready_delay);
    sb.push_back(model(l, s));
    do_start(l);
    send_samples(s, gap);
    wait_result(ready_delay);
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.abort     = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.res_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_zero_outputs("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic burst
    smp = '{10'd3, 10'd900, 10'd12, 10'd1023, 10'd1023};
    run_burst(8'd5, smp, 0, 0);

    // Ties and zeros, with res_ready held high in advance
    bus.res_ready = 1'b1;
    smp = '{10'd0, 10'd0, 10'd0, 10'd0};
    run_burst(8'd4, smp, 0, 0);
    bus.res_ready = 1'b1;
    smp = '{10'd7, 10'd7, 10'd6};
    run_burst(8'd3, smp, 0, 0);

    // Empty burst
    smp = {};
    run_burst(8'd0, smp, 0, 1);

    // Stalls and backpressure
    smp = '{10'd5, 10'd600, 10'd2};
    run_burst(8'd3, smp, 2, 4);

    // Abort after 2 of 4 samples; the sample offered with abort must not be taken
    do_start(8'd4);
    smp = '{10'd10, 10'd20};
    send_samples(smp, 0);
    bus.abort   = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 10'd1000;
    #1 check_eq("abort_s_ready", bus.s_ready, 0);
    @(negedge clk);
    bus.abort   = 1'b0;
    bus.s_valid = 1'b0;
    check_eq("abort_busy",      bus.busy,      0);
    check_eq("abort_res_valid", bus.res_valid, 0);
    check_eq("abort_s_ready_after", bus.s_ready, 0);
    check_eq("abort_sb_empty", sb.size(), 0);

    // start during ACCUM is ignored
    smp = '{10'd7, 10'd500, 10'd9};
    sb.push_back(model(8'd3, smp));
    do_start(8'd3);
    smp = '{10'd7};
    send_samples(smp, 0);
    bus.start = 1'b1;
    bus.len   = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("ign_start_busy",  bus.busy,      1);
    check_eq("ign_start_valid", bus.res_valid, 0);
    check_eq("ign_start_ready", bus.s_ready,   1);
    smp = '{10'd500, 10'd9};
    send_samples(smp, 0);
    wait_result(0);

    smp = '{10'd42};
    run_burst(8'd1, smp, 0, 0);

    // Reset mid-burst in ACCUM
    do_start(8'd4);
    smp = '{10'd300};
    send_samples(smp, 0);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("rst_accum");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-burst in RESULT
    do_start(8'd2);
    smp = '{10'd100, 10'd3};
    send_samples(smp, 0);
    check_eq("pre_rst_res_valid", bus.res_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("rst_result");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    smp = '{10'd1, 10'd2, 10'd3};
    run_burst(8'd3, smp, 0, 0);

    // Longer burst with coarse values to force repeated ties
    smp = {};
    for (int i = 0; i < 20; i++) smp.push_back(10'($urandom_range(0, 15) * 64));
    run_burst(8'd20, smp, 1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/max_search_ctrl.md
# max_search_ctrl

Sequencing controller that finds the maximum of a burst of 10-bit samples by streaming each one through a single 10-bit unsigned greater-than comparator instance. It accepts a burst length on `start`, takes samples over a valid/ready stream, and keeps the running maximum and its index. It returns the result on a valid/ready result port. It sits between a sample source (ADC buffer or memory reader) and downstream decision logic, and is the only user of its comparator.

## Interface
- `CNT_W`, default 8: width of the burst length, sample counter and index. Maximum burst is 2^CNT_W − 1 samples.
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begins a burst. Sampled only in IDLE.
- `len` in CNT_W: number of samples in the burst. Captured when `start` is accepted.
- `abort` in 1: synchronous cancel. Acts only in ACCUM.
- `s_valid` in 1: sample valid.
- `s_ready` out 1: controller can accept a sample.
- `s_data` in 10: unsigned sample.
- `busy` out 1: high in ACCUM and RESULT.
- `res_valid` out 1: result valid.
- `res_ready` in 1: consumer accepts the result.
- `res_max` out 10: maximum sample value.
- `res_idx` out CNT_W: zero-based index of the first occurrence of the maximum.
- `res_empty` out 1: the burst had `len` = 0.

## Operation
- **States:** IDLE, ACCUM, RESULT. Encode as 2 bits. Treat the unused encoding as IDLE.
- **IDLE:** `s_ready` = 0, `busy` = 0, `res_valid` = 0.
  - On `start` = 1, capture `len` and clear `cnt`.
  - If `len` = 0: go to RESULT with `res_max` = 0, `res_idx` = 0, `res_empty` = 1.
  - Otherwise: go to ACCUM with `res_empty` = 0.
- **ACCUM:** `s_ready` = 1.
  - A sample is accepted on `s_valid && s_ready`.
  - On the first sample (`cnt` = 0): load `max` = `s_data`, `idx` = 0.
  - On later samples: the comparator gets A = `s_data`, B = `max`. If `greaterthan` = 1, load `max` = `s_data` and `idx` = `cnt`. Otherwise hold.
  - Comparison is strict, so on a tie the earliest index wins.
  - `cnt` increments on every accepted sample.
  - When the accepted sample has `cnt` = `len` − 1, go to RESULT.
- **RESULT:** `res_valid` = 1. `res_max`, `res_idx` and `res_empty` hold stable until `res_valid && res_ready`, then go to IDLE.
- **Abort:** `abort` = 1 in ACCUM goes to IDLE in the next cycle. No result is produced and any sample presented in that cycle is not accepted, so `s_ready` is forced to 0 while `abort` = 1. `abort` in IDLE or RESULT is ignored.
- **Ignored inputs:**
  - `start` outside IDLE is ignored. `start` in the same cycle as the result handshake is ignored; the controller must be in IDLE first.
  - `s_valid` outside ACCUM is ignored, with no side effects.
- **Widths:** all comparisons are 10-bit unsigned. `cnt` never wraps, because `len` ≤ 2^CNT_W − 1 and `cnt` stops at `len` − 1.

## Timing
- **Reset (asynchronous, `rst_n` = 0):** state = IDLE. `s_ready`, `busy`, `res_valid`, `res_empty` = 0. `res_max` = 0, `res_idx` = 0, `cnt` = 0. Reset mid-burst discards the burst immediately, with no result.
- **Start:** accepted on edge T. `s_ready` = 1 and `busy` = 1 from cycle T+1 for `len` > 0. For `len` = 0, `res_valid` = 1 from T+1.
- **Throughput:** one sample per cycle with `s_valid` held high. Gaps in `s_valid` stall without losing state.
- **Result latency:** `res_valid` rises the cycle after the last sample is accepted. A burst of N samples with no gaps gives `res_valid` at T+1+N.
- **`s_ready`:** comes from registered state and is not combinationally dependent on `s_valid`.
- **Back-to-back bursts:** minimum one IDLE cycle between a result handshake and the next accepted `start`.
- **`res_ready`:** may be held high in advance. The handshake then completes in the first RESULT cycle.

## Test plan
- **Basic burst:** `len` = 5, samples 3, 900, 12, 1023, 1023 with no gaps → `res_valid` at T+6, `res_max` = 1023, `res_idx` = 3, `res_empty` = 0.
- **Ties and zeros:** `len` = 4, samples 0, 0, 0, 0 → `res_max` = 0, `res_idx` = 0. Then `len` = 3, samples 7, 7, 6 → `res_idx` = 0.
- **Empty burst:** `len` = 0 → `res_valid` = 1 the next cycle, `res_empty` = 1, `res_max` = 0, `s_ready` never asserted.
- **Stalls and backpressure:** `len` = 3, samples 5, 600, 2 with `s_valid` low for 2 cycles between each, `res_ready` low for 4 cycles → outputs stable throughout; result 600, index 1; return to IDLE only on the handshake.
- **Abort and start ignored:** abort after 2 of 4 samples → no `res_valid`, IDLE next cycle. A `start` pulse issued during ACCUM is ignored. A new burst with `len` = 1, sample 42 → `res_max` = 42, `res_idx` = 0.
- **Reset mid-burst:** assert `rst_n` = 0 asynchronously in ACCUM and in RESULT → all outputs 0 without waiting for a clock edge. The next burst works normally.
